keypad_key_detector: RTL and testbench

//  Consumes the 1 kHz column scan and the 4 keypad row lines. Produces one debounced 4-bit key code per press.
//  Per 4-column frame: resolves one pressed key, debounces across frames, pulses key_valid once per press.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_row_sync.sv | 36 +++
 rtl/keypad_key_detector.sv | 178 +++++++++++++++++
 tb/tb_keypad_key_detector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad key detector: FSM states, key code type and
// the position-to-legend mapping used by display logic.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} kd_state_t;

  typedef logic [3:0] key_code_t;

  localparam int         NUM_ROWS = 4;
  localparam logic [1:0] LAST_COL = 2'd3;

  // Standard 4x4 legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * -> E, # -> F.
  function automatic logic [3:0] key_to_hex(key_code_t code);
    logic [3:0] hex;
    hex = 4'h0;
    case (code)
      4'b0000: hex = 4'h1;
      4'b0001: hex = 4'h2;
      4'b0010: hex = 4'h3;
      4'b0011: hex = 4'hA;
      4'b0100: hex = 4'h4;
      4'b0101: hex = 4'h5;
      4'b0110: hex = 4'h6;
      4'b0111: hex = 4'hB;
      4'b1000: hex = 4'h7;
      4'b1001: hex = 4'h8;
      4'b1010: hex = 4'h9;
      4'b1011: hex = 4'hC;
      4'b1100: hex = 4'hE;
      4'b1101: hex = 4'h0;
      4'b1110: hex = 4'hF;
      4'b1111: hex = 4'hD;
      default: hex = 4'h0;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Row-line synchronizer with a matching column_index delay, so every synced
// row sample arrives paired with the column that produced it.
module keypad_row_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [1:0] column_index,
  input  logic [3:0] row_in,
  output logic [1:0] column_sync,
  output logic [3:0] row_sync
);

  logic [3:0] row_pipe_reg [SYNC_STAGES];
  logic [1:0] col_pipe_reg [SYNC_STAGES];

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        row_pipe_reg[i] <= '0;
        col_pipe_reg[i] <= '0;
      end
    end else begin
      row_pipe_reg[0] <= row_in;
      col_pipe_reg[0] <= column_index;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        row_pipe_reg[i] <= row_pipe_reg[i-1];
        col_pipe_reg[i] <= col_pipe_reg[i-1];
      end
    end
  end

  assign row_sync    = row_pipe_reg[SYNC_STAGES-1];
  assign column_sync = col_pipe_reg[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_key_detector.sv
// Per-frame key resolution plus press/release debounce for the scanned keypad.
// Define KEYPAD_REPEAT_EN to add auto-repeat key_valid pulses while a key is held.
module keypad_key_detector
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int REPEAT_DELAY    = 125,
  parameter int REPEAT_RATE     = 25
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [1:0] column_index,
  input  logic [3:0] row_in,
  output key_code_t  key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       multi_key
);

  localparam int CNT_MAX = (DEBOUNCE_FRAMES > REPEAT_DELAY)
      ? ((DEBOUNCE_FRAMES > REPEAT_RATE) ? DEBOUNCE_FRAMES : REPEAT_RATE)
      : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_FRAMES);

  logic [1:0] column_sync;
  logic [3:0] row_sync;

  keypad_row_sync #(.SYNC_STAGES(SYNC_STAGES)) u_row_sync (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .column_index (column_index),
    .row_in       (row_in),
    .column_sync  (column_sync),
    .row_sync     (row_sync)
  );

  // Frame accumulators; the hit count only needs to distinguish 0, 1 and many.
  logic [1:0] hit_cnt_reg, hit_cnt_next;
  key_code_t  frame_code_reg, frame_code_next;
  logic       frame_multi_reg, frame_multi_next;
  logic [1:0] row_idx;
  logic       sample_hit, sample_multi, frame_end;
  logic       frame_none, frame_single, frame_multi;

  always_comb begin
    row_idx = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_sync[r]) row_idx = 2'(r);
    end
  end

  assign sample_hit       = $onehot(row_sync);
  assign sample_multi     = (row_sync != 4'd0) && !sample_hit;
  assign hit_cnt_next     = (sample_hit && hit_cnt_reg != 2'd2) ? hit_cnt_reg + 2'd1 : hit_cnt_reg;
  assign frame_code_next  = sample_hit ? {row_idx, column_sync} : frame_code_reg;
  assign frame_multi_next = frame_multi_reg | sample_multi;
  assign frame_end        = (column_sync == LAST_COL);

  // A multi-row sample with no clean hit still makes the frame a multi frame.
  assign frame_none   = (hit_cnt_next == 2'd0) && !frame_multi_next;
  assign frame_single = (hit_cnt_next == 2'd1) && !frame_multi_next;
  assign frame_multi  = !frame_none && !frame_single;

  always_ff @(posedge slow_clk) begin
    if (rst || frame_end) begin
      hit_cnt_reg     <= '0;
      frame_code_reg  <= '0;
      frame_multi_reg <= 1'b0;
    end else begin
      hit_cnt_reg     <= hit_cnt_next;
      frame_code_reg  <= frame_code_next;
      frame_multi_reg <= frame_multi_next;
    end
  end

  kd_state_t        state_reg;
  key_code_t        cand_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic             same_key, diff_key;

  assign cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign same_key = frame_single && (frame_code_next == key_code);
  assign diff_key = frame_none || (frame_single && (frame_code_next != key_code));

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LIMIT = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RATE_LIMIT  = CNT_W'(REPEAT_RATE);
  logic [CNT_W-1:0] rep_cnt_reg, rep_inc;
  logic             rep_first_reg;
  assign rep_inc = (&rep_cnt_reg) ? rep_cnt_reg : rep_cnt_reg + CNT_W'(1);
`endif

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cand_reg    <= '0;
      cnt_reg     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      if (frame_end) begin
        multi_key <= frame_multi;
        case (state_reg)
          IDLE: begin
            if (frame_single) begin
              state_reg <= PRESS_DB;
              cand_reg  <= frame_code_next;
              cnt_reg   <= CNT_W'(1);
            end
          end
          PRESS_DB: begin
            if (frame_single && frame_code_next == cand_reg) begin
              if (cnt_inc >= DB_LIMIT) begin
                state_reg   <= HELD;
                key_code    <= cand_reg;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
                cnt_reg     <= '0;
              end else begin
                cnt_reg <= cnt_inc;
              end
            end else begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end
          HELD: begin
            if (diff_key) begin
              state_reg <= RELEASE_DB;
              cnt_reg   <= CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_reg   <= '0;
              rep_first_reg <= 1'b1;
`endif
            end
`ifdef KEYPAD_REPEAT_EN
            else if (same_key) begin
              if (rep_inc >= (rep_first_reg ? REP_DELAY_LIMIT : REP_RATE_LIMIT)) begin
                key_valid     <= 1'b1;
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b0;
              end else begin
                rep_cnt_reg <= rep_inc;
              end
            end
`endif
          end
          RELEASE_DB: begin
            if (same_key) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
            end else if (diff_key) begin
              if (cnt_inc >= DB_LIMIT) begin
                state_reg   <= IDLE;
                key_pressed <= 1'b0;
                cnt_reg     <= '0;
              end else begin
                cnt_reg <= cnt_inc;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_key_detector.sv
// Scoreboard bench for keypad_key_detector: expected key_valid / multi_key
// pulses are queued with their cycle as frames are driven, then matched live.
module tb_keypad_key_detector;
  import keypad_pkg::*;

  // Column-3 drive -> two sync stages -> registered output.
  localparam int LAT = 3;

  logic       slow_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] column_index = 2'd0;
  logic [3:0] row_in = 4'd0;
  key_code_t  key_code;
  logic       key_valid, key_pressed, multi_key;

  keypad_key_detector dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .column_index (column_index),
    .row_in       (row_in),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed),
    .multi_key    (multi_key)
  );

  always #5 slow_clk = ~slow_clk;

  int cyc = 0;
  always @(posedge slow_clk) cyc <= cyc + 1;

  typedef struct {
    key_code_t code;
    int        cyc;
  } exp_t;

  exp_t valid_q[$];
  exp_t multi_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always @(negedge slow_clk) begin
    exp_t e;
    if (key_valid === 1'b1) begin
      n_checks++;
      if (valid_q.size() == 0) begin
        $display("FAIL key_valid_unexpected: pulse code=%h at cycle %0d, required no pulse", key_code, cyc);
      end else begin
        e = valid_q.pop_front();
        if (key_code !== e.code || cyc != e.cyc)
          $display("FAIL key_valid: code=%h cycle=%0d, required code=%h cycle=%0d", key_code, cyc, e.code, e.cyc);
        else begin
          n_pass++;
          $display("key_valid code=%h cycle=%0d ok", key_code, cyc);
        end
      end
    end
    while (valid_q.size() != 0 && valid_q[0].cyc < cyc) begin
      e = valid_q.pop_front();
      n_checks++;
      $display("FAIL key_valid_missing: no pulse by cycle %0d, required code=%h at cycle %0d", cyc, e.code, e.cyc);
    end
    if (multi_key === 1'b1) begin
      n_checks++;
      if (multi_q.size() == 0) begin
        $display("FAIL multi_key_unexpected: pulse at cycle %0d, required no pulse", cyc);
      end else begin
        e = multi_q.pop_front();
        if (cyc != e.cyc)
          $display("FAIL multi_key: pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
        else begin
          n_pass++;
          $display("multi_key cycle=%0d ok", cyc);
        end
      end
    end
    while (multi_q.size() != 0 && multi_q[0].cyc < cyc) begin
      e = multi_q.pop_front();
      n_checks++;
      $display("FAIL multi_key_missing: no pulse by cycle %0d, required at cycle %0d", cyc, e.cyc);
    end
  end

  function automatic logic [15:0] key_bit(key_code_t c);
    logic [15:0] one;
    one = 16'd1;
    return one << c;
  endfunction

  // Drives one 4-column frame; keys bit {row,col} set means that key is down.
  task automatic drive_frame(input logic [15:0] keys, output int col3_cyc);
    for (int c = 0; c < 4; c++) begin
      @(posedge slow_clk);
      #1;
      column_index = 2'(c);
      for (int r = 0; r < 4; r++) row_in[r] = keys[r*4 + c];
      col3_cyc = cyc;
    end
  endtask

  task automatic drive_frames(input logic [15:0] keys, input int n);
    int k;
    for (int f = 0; f < n; f++) drive_frame(keys, k);
  endtask

  task automatic press_and_expect(input key_code_t code, input int n);
    int k;
    for (int f = 1; f <= n; f++) begin
      drive_frame(key_bit(code), k);
      if (f == 5) valid_q.push_back('{code, k + LAT});
    end
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b1;
    drive_frame(16'd0, k);
    n_checks++;
    if ({key_valid, key_pressed, multi_key} !== 3'b000 || key_code !== 4'd0)
      $display("FAIL reset_outputs: valid=%b pressed=%b multi=%b code=%h, required all 0", key_valid, key_pressed, multi_key, key_code);
    else n_pass++;
    $display("reset outputs valid=%b pressed=%b multi=%b code=%h", key_valid, key_pressed, multi_key, key_code);
    rst = 1'b0;
  endtask

  task automatic test_single_press;
    int k;
    for (int f = 1; f <= 10; f++) begin
      drive_frame(key_bit(4'b0110), k);
      if (f == 5) begin
        valid_q.push_back('{4'b0110, k + LAT});
        n_checks++;
        if (key_pressed !== 1'b0) $display("FAIL press_early: key_pressed=%b after 4 frames, required 0", key_pressed);
        else n_pass++;
      end
      if (f == 6) begin
        n_checks++;
        if (key_pressed !== 1'b1 || key_code !== 4'b0110)
          $display("FAIL press_accept: pressed=%b code=%h, required 1 and 6", key_pressed, key_code);
        else n_pass++;
      end
    end
    drive_frames(16'd0, 5);
    n_checks++;
    if (key_pressed !== 1'b1) $display("FAIL release_early: key_pressed=%b after 4 release frames, required 1", key_pressed);
    else n_pass++;
    drive_frames(16'd0, 1);
    n_checks++;
    if (key_pressed !== 1'b0 || key_code !== 4'b0110)
      $display("FAIL release_accept: pressed=%b code=%h, required 0 and 6", key_pressed, key_code);
    else n_pass++;
    $display("single press row1/col2 done pressed=%b code=%h", key_pressed, key_code);
  endtask

  task automatic test_bounce;
    drive_frames(key_bit(4'b1000), 2);
    drive_frames(16'd0, 1);
    press_and_expect(4'b1000, 5);
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL bounce_early: key_pressed=%b after 4 stable frames, required 0", key_pressed);
    else n_pass++;
    drive_frames(key_bit(4'b1000), 1);
    n_checks++;
    if (key_pressed !== 1'b1 || key_code !== 4'b1000)
      $display("FAIL bounce_accept: pressed=%b code=%h, required 1 and 8", key_pressed, key_code);
    else n_pass++;
    drive_frames(16'd0, 6);
    $display("bounce press done pressed=%b code=%h", key_pressed, key_code);
  endtask

  task automatic test_multi;
    int k;
    drive_frame(key_bit(4'b0001) | key_bit(4'b1101), k);
    multi_q.push_back('{4'd0, k + LAT});
    drive_frame(key_bit(4'b0000) | key_bit(4'b0101), k);
    multi_q.push_back('{4'd0, k + LAT});
    drive_frames(16'd0, 2);
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL multi_idle: key_pressed=%b, required 0", key_pressed);
    else n_pass++;
    // A multi frame during press debounce restarts the debounce.
    drive_frames(key_bit(4'b0011), 4);
    drive_frame(key_bit(4'b0011) | key_bit(4'b0111), k);
    multi_q.push_back('{4'd0, k + LAT});
    press_and_expect(4'b0011, 6);
    n_checks++;
    if (key_pressed !== 1'b1 || key_code !== 4'b0011)
      $display("FAIL multi_restart: pressed=%b code=%h, required 1 and 3", key_pressed, key_code);
    else n_pass++;
    drive_frames(16'd0, 6);
    $display("multi-key frames done pressed=%b", key_pressed);
  endtask

  task automatic test_held_dropout;
    int k;
    press_and_expect(4'b1111, 6);
    drive_frame(key_bit(4'b1111) | key_bit(4'b0011), k);
    multi_q.push_back('{4'd0, k + LAT});
    drive_frames(16'd0, 2);
    drive_frames(key_bit(4'b1111), 4);
    n_checks++;
    if (key_pressed !== 1'b1 || key_code !== 4'b1111)
      $display("FAIL dropout_hold: pressed=%b code=%h, required 1 and f", key_pressed, key_code);
    else n_pass++;
    drive_frames(16'd0, 6);
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL dropout_release: key_pressed=%b, required 0", key_pressed);
    else n_pass++;
    $display("held dropout done code=%h", key_code);
  endtask

  task automatic test_reset_mid_press;
    int k;
    drive_frames(key_bit(4'b1001), 3);
    rst = 1'b1;
    drive_frame(16'd0, k);
    n_checks++;
    if ({key_valid, key_pressed, multi_key} !== 3'b000 || key_code !== 4'd0)
      $display("FAIL midreset_outputs: valid=%b pressed=%b multi=%b code=%h, required all 0", key_valid, key_pressed, multi_key, key_code);
    else n_pass++;
    rst = 1'b0;
    press_and_expect(4'b1001, 6);
    n_checks++;
    if (key_pressed !== 1'b1 || key_code !== 4'b1001)
      $display("FAIL midreset_accept: pressed=%b code=%h, required 1 and 9", key_pressed, key_code);
    else n_pass++;
    drive_frames(16'd0, 6);
    $display("reset mid press done code=%h", key_code);
  endtask

  task automatic test_long_hold;
    int k;
    for (int f = 1; f <= 200; f++) begin
      drive_frame(key_bit(4'b0010), k);
`ifdef KEYPAD_REPEAT_EN
      if (f == 5 || f == 130 || f == 155 || f == 180) valid_q.push_back('{4'b0010, k + LAT});
`else
      if (f == 5) valid_q.push_back('{4'b0010, k + LAT});
`endif
    end
    drive_frames(16'd0, 6);
    n_checks++;
    if (key_pressed !== 1'b0 || key_code !== 4'b0010)
      $display("FAIL long_hold_release: pressed=%b code=%h, required 0 and 2", key_pressed, key_code);
    else n_pass++;
    $display("long hold done code=%h", key_code);
  endtask

  initial begin
    exp_t e;
    test_reset;
    test_single_press;
    test_bounce;
    test_multi;
    test_held_dropout;
    test_reset_mid_press;
    test_long_hold;
    drive_frames(16'd0, 3);
    while (valid_q.size() != 0) begin
      e = valid_q.pop_front();
      n_checks++;
      $display("FAIL key_valid_leftover: never seen, required code=%h at cycle %0d", e.code, e.cyc);
    end
    while (multi_q.size() != 0) begin
      e = multi_q.pop_front();
      n_checks++;
      $display("FAIL multi_key_leftover: never seen, required at cycle %0d", e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
